// File: rtl/img_coder_pkg.sv
// Shared constants, types and saturation helpers for the row-wise 5/3 image coder.
package img_coder_pkg;

    localparam int PIX_W     = 16;
    localparam int COEF_W    = 18;
    localparam int ROW_PAIRS = 32;
    localparam int ROWS      = 64;
    localparam int DSHIFT    = 3;
    localparam int SLOT_W    = 6;
    localparam int ROW_W     = 6;

    typedef logic [SLOT_W-1:0]        slot_t;
    typedef logic [ROW_W-1:0]         row_t;
    typedef logic signed [COEF_W-1:0] coef_t;

    // Slot schedule: lead pad, 32 pair slots, trail pad.
    localparam slot_t SLOT_LEAD       = slot_t'(0);
    localparam slot_t SLOT_FIRST_PAIR = slot_t'(1);
    localparam slot_t SLOT_FIRST_OUT  = slot_t'(2);
    localparam slot_t SLOT_TRAIL      = slot_t'(ROW_PAIRS + 1);
    localparam row_t  ROW_LAST        = row_t'(ROWS - 1);

    localparam coef_t U8_MAX = coef_t'(255);
    localparam coef_t S4_MAX = coef_t'(7);
    localparam coef_t S4_MIN = coef_t'(-8);

    // Zero-extend an unsigned pixel into the signed coefficient domain.
    function automatic coef_t pix_to_coef(input logic [PIX_W-1:0] p);
        return coef_t'({{(COEF_W-PIX_W){1'b0}}, p});
    endfunction

    // Clamp a coefficient to the unsigned byte range 0..255.
    function automatic logic [7:0] sat_u8(input coef_t v);
        if (v[COEF_W-1]) begin
            return 8'h00;
        end else if (v > U8_MAX) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    // Clamp a coefficient to a 4-bit two's complement nibble (-8..7).
    function automatic logic [3:0] sat_s4(input coef_t v);
        if (v < S4_MIN) begin
            return 4'h8;
        end else if (v > S4_MAX) begin
            return 4'h7;
        end else begin
            return v[3:0];
        end
    endfunction

endpackage

// File: rtl/img_coder_lifting53_row.sv
// One-row 5/3 integer lifting: buffers the previous pixel pair and the previous
// detail coefficient, and produces d[n]/s[n] for the pair being finished.
// The right neighbour x[2n+2] is the even pixel on the input this cycle, except
// at the trail pad where the row end is mirrored (x[64] = x[62]).
module lifting53_row
    import img_coder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,         // active-high async reset
    input  logic [PIX_W-1:0] data_in_even,
    input  logic [PIX_W-1:0] data_in_odd,
    input  logic             load,          // capture the current pair
    input  logic             finish,        // pair in buffer is being emitted
    input  logic             first,         // finishing pair 0 of the row
    input  logic             use_ext,       // mirror the row end
    output coef_t            s_coef,
    output coef_t            d_coef
);

    logic [PIX_W-1:0] even_r;
    logic [PIX_W-1:0] odd_r;
    coef_t            d_prev;

    coef_t x_even;
    coef_t x_odd;
    coef_t x_next;
    coef_t pred_sum;
    coef_t d_left;
    coef_t upd_sum;

    // Predict and update steps for the buffered pair.
    always_comb begin
        x_even   = pix_to_coef(even_r);
        x_odd    = pix_to_coef(odd_r);
        x_next   = use_ext ? pix_to_coef(even_r) : pix_to_coef(data_in_even);
        pred_sum = x_even + x_next;
        d_coef   = x_odd - (pred_sum >>> 1);
        // Row start mirrors the left detail: d[-1] = d[0], so nothing leaks from the previous row.
        d_left   = first ? d_coef : d_prev;
        upd_sum  = d_left + d_coef + coef_t'(2);
        s_coef   = x_even + (upd_sum >>> 2);
    end

    // Pair buffer and left-neighbour detail register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            even_r <= '0;
            odd_r  <= '0;
            d_prev <= '0;
        end else begin
            if (load) begin
                even_r <= data_in_even;
                odd_r  <= data_in_odd;
            end
            if (finish) begin
                d_prev <= d_coef;
            end
        end
    end

endmodule

// File: rtl/img_coder.sv
// Row-wise lossy 5/3 wavelet coder for a 64x64 frame, one pixel pair per clock.
// Framing is a free-running 34-slot row schedule: lead pad, 32 pairs, trail pad.
// Each finished pair becomes one byte: {sat(s)[7:4], sat(d>>>DSHIFT) as 4-bit}.
// Build option: define IMG_CODER_ROWHDR_EN to emit a {2'b11,row} header byte
// at the slot-1 edge of every row (33 valid bytes per row instead of 32).
module img_coder
    import img_coder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,         // ACTIVE-HIGH asynchronous reset despite the name
    input  logic [PIX_W-1:0] data_in_even,
    input  logic [PIX_W-1:0] data_in_odd,
    output logic             output_valid,
    output logic [7:0]       byte_out
);

    slot_t slot;

    logic  load;
    logic  finish;
    logic  first;
    logic  use_ext;
    coef_t s_coef;
    coef_t d_coef;
    coef_t d_scaled;
    logic [7:0] s_u8;
    logic [3:0] d_s4;
    logic [7:0] byte_next;

    // Slot decode for the lifting datapath.
    always_comb begin
        load    = (slot >= SLOT_FIRST_PAIR) && (slot < SLOT_TRAIL);
        finish  = (slot >= SLOT_FIRST_OUT);
        first   = (slot == SLOT_FIRST_OUT);
        use_ext = (slot == SLOT_TRAIL);
    end

    lifting53_row u_lift (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_even (data_in_even),
        .data_in_odd  (data_in_odd),
        .load         (load),
        .finish       (finish),
        .first        (first),
        .use_ext      (use_ext),
        .s_coef       (s_coef),
        .d_coef       (d_coef)
    );

    // Byte packer: top nibble of the clamped low band, signed nibble of the scaled detail.
    always_comb begin
        d_scaled  = d_coef >>> DSHIFT;
        s_u8      = sat_u8(s_coef);
        d_s4      = sat_s4(d_scaled);
        byte_next = (s_u8 & 8'hF0) | {4'h0, d_s4};
    end

    // Free-running slot counter, wrapping at the trail pad.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            slot <= SLOT_LEAD;
        end else if (slot == SLOT_TRAIL) begin
            slot <= SLOT_LEAD;
        end else begin
            slot <= slot + slot_t'(1);
        end
    end

`ifdef IMG_CODER_ROWHDR_EN
    // The row index is only observable through the header byte, so it lives with the header.
    row_t row;

    // Row counter, advancing when the slot schedule wraps.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            row <= '0;
        end else if (slot == SLOT_TRAIL) begin
            row <= (row == ROW_LAST) ? '0 : row + row_t'(1);
        end
    end

    // Output register: data bytes, plus the row header at the slot-1 edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            output_valid <= 1'b0;
            byte_out     <= 8'h00;
        end else if (finish) begin
            output_valid <= 1'b1;
            byte_out     <= byte_next;
        end else if (slot == SLOT_FIRST_PAIR) begin
            output_valid <= 1'b1;
            byte_out     <= {2'b11, row};
        end else begin
            output_valid <= 1'b0;
        end
    end
`else
    // Output register: data bytes only; idle slots hold the last byte.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            output_valid <= 1'b0;
            byte_out     <= 8'h00;
        end else if (finish) begin
            output_valid <= 1'b1;
            byte_out     <= byte_next;
        end else begin
            output_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_img_coder.sv
// Directed bench for img_coder: constant, ramp and saturating-detail rows,
// mid-row reset, and a full 64-row frame byte count.
module tb_img_coder;

`ifdef IMG_CODER_ROWHDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    localparam int MODE_CONST = 0;
    localparam int MODE_RAMP  = 1;
    localparam int MODE_POS   = 2;
    localparam int MODE_NEG   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in_even;
    logic [15:0] data_in_odd;
    logic        output_valid;
    logic [7:0]  byte_out;

    int n_checks = 0;
    int n_pass   = 0;
    int bench_row = 0;
    int obs_row   = 0;
    logic [7:0] last_byte = 8'h00;
    logic       obs_v [34];
    logic [7:0] obs_b [34];

    always #5 clk = ~clk;

    img_coder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_even (data_in_even),
        .data_in_odd  (data_in_odd),
        .output_valid (output_valid),
        .byte_out     (byte_out)
    );

    // Expected {valid, byte} after the edge of slot k, from the hand-derived values.
    function automatic logic [8:0] expect_slot(input int mode, input int k, input int row,
                                               input logic [7:0] last);
        logic [7:0] t;
        logic [5:0] r;
        r = row[5:0];
        if (k >= 2) begin
            case (mode)
                MODE_CONST: return {1'b1, 8'h60};
                MODE_RAMP: begin
                    if (k - 2 == 31) return {1'b1, 8'h30};
                    t = 8'(2 * (k - 2));
                    return {1'b1, t[7:4], 4'h0};
                end
                MODE_POS: return {1'b1, 8'h67};
                default:  return {1'b1, 8'h68};
            endcase
        end
        if (k == 1 && HDR) return {1'b1, 2'b11, r};
        return {1'b0, last};
    endfunction

    // Drive nedges slots of a row (starting at slot 0) and record the outputs.
    task automatic run_row(input int mode, input int nedges);
        obs_row = bench_row;
        for (int k = 0; k < nedges; k++) begin
            if (k >= 1 && k <= 32) begin
                case (mode)
                    MODE_CONST: begin data_in_even = 16'd100; data_in_odd = 16'd100; end
                    MODE_RAMP: begin
                        data_in_even = 16'(2 * (k - 1));
                        data_in_odd  = 16'(2 * (k - 1) + 1);
                    end
                    MODE_POS: begin data_in_even = 16'd0;   data_in_odd = 16'd200; end
                    default:  begin data_in_even = 16'd200; data_in_odd = 16'd0;   end
                endcase
            end else begin
                data_in_even = 16'hFFFF;
                data_in_odd  = 16'hFFFF;
            end
            @(posedge clk);
            #1;
            obs_v[k] = output_valid;
            obs_b[k] = byte_out;
        end
        if (nedges == 34) bench_row = (bench_row + 1) % 64;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        data_in_even = 16'h1234;
        data_in_odd  = 16'h5678;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", output_valid);
        else n_pass++;
        n_checks++;
        if (byte_out !== 8'h00) $display("FAIL reset_byte: got %h expected 00", byte_out);
        else n_pass++;
        rst_n = 1'b0;
        bench_row = 0;
        last_byte = 8'h00;
    endtask

    task automatic test_constant();
        logic [8:0] e;
        for (int r = 0; r < 2; r++) begin
            run_row(MODE_CONST, 34);
            for (int k = 0; k < 34; k++) begin
                e = expect_slot(MODE_CONST, k, obs_row, last_byte);
                n_checks++;
                if (obs_v[k] !== e[8]) $display("FAIL const_valid row %0d slot %0d: got %b expected %b", obs_row, k, obs_v[k], e[8]);
                else n_pass++;
                n_checks++;
                if (obs_b[k] !== e[7:0]) $display("FAIL const_byte row %0d slot %0d: got %h expected %h", obs_row, k, obs_b[k], e[7:0]);
                else n_pass++;
                last_byte = e[7:0];
            end
        end
    endtask

    task automatic test_ramp();
        logic [8:0] e;
        run_row(MODE_RAMP, 34);
        for (int k = 0; k < 34; k++) begin
            e = expect_slot(MODE_RAMP, k, obs_row, last_byte);
            n_checks++;
            if (obs_v[k] !== e[8]) $display("FAIL ramp_valid slot %0d: got %b expected %b", k, obs_v[k], e[8]);
            else n_pass++;
            n_checks++;
            if (obs_b[k] !== e[7:0]) $display("FAIL ramp_byte slot %0d: got %h expected %h", k, obs_b[k], e[7:0]);
            else n_pass++;
            last_byte = e[7:0];
        end
    endtask

    // Positive then negative saturating detail rows, back to back across a row boundary.
    task automatic test_detail_clamp();
        logic [8:0] e;
        for (int m = MODE_POS; m <= MODE_NEG; m++) begin
            run_row(m, 34);
            for (int k = 0; k < 34; k++) begin
                e = expect_slot(m, k, obs_row, last_byte);
                n_checks++;
                if (obs_v[k] !== e[8]) $display("FAIL clamp_valid mode %0d slot %0d: got %b expected %b", m, k, obs_v[k], e[8]);
                else n_pass++;
                n_checks++;
                if (obs_b[k] !== e[7:0]) $display("FAIL clamp_byte mode %0d slot %0d: got %h expected %h", m, k, obs_b[k], e[7:0]);
                else n_pass++;
                last_byte = e[7:0];
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] e;
        // Bench is now at row 5; stop with the DUT sitting in slot 15.
        run_row(MODE_CONST, 15);
        n_checks++;
        if (obs_v[14] !== 1'b1 || obs_b[14] !== 8'h60)
            $display("FAIL pre_reset_out: got %b/%h expected 1/60", obs_v[14], obs_b[14]);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (output_valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", output_valid);
        else n_pass++;
        n_checks++;
        if (byte_out !== 8'h00) $display("FAIL midreset_byte: got %h expected 00", byte_out);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bench_row = 0;
        last_byte = 8'h00;
        run_row(MODE_CONST, 34);
        for (int k = 0; k < 34; k++) begin
            e = expect_slot(MODE_CONST, k, obs_row, last_byte);
            n_checks++;
            if (obs_v[k] !== e[8]) $display("FAIL restart_valid slot %0d: got %b expected %b", k, obs_v[k], e[8]);
            else n_pass++;
            n_checks++;
            if (obs_b[k] !== e[7:0]) $display("FAIL restart_byte slot %0d: got %h expected %h", k, obs_b[k], e[7:0]);
            else n_pass++;
            last_byte = e[7:0];
        end
    endtask

    task automatic test_frame();
        logic [8:0] e;
        int valid_cnt;
        int exp_cnt;
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        bench_row = 0;
        last_byte = 8'h00;
        valid_cnt = 0;
        exp_cnt = HDR ? 64 * 33 : 64 * 32;
        for (int r = 0; r < 65; r++) begin
            run_row(MODE_CONST, 34);
            for (int k = 0; k < 34; k++) begin
                e = expect_slot(MODE_CONST, k, obs_row, last_byte);
                n_checks++;
                if (obs_v[k] !== e[8] || obs_b[k] !== e[7:0])
                    $display("FAIL frame_out row %0d slot %0d: got %b/%h expected %b/%h", obs_row, k, obs_v[k], obs_b[k], e[8], e[7:0]);
                else n_pass++;
                last_byte = e[7:0];
                if (r < 64 && obs_v[k] === 1'b1) valid_cnt++;
            end
        end
        n_checks++;
        if (valid_cnt !== exp_cnt) $display("FAIL frame_count: got %0d expected %0d", valid_cnt, exp_cnt);
        else n_pass++;
    endtask

    initial begin
        data_in_even = '0;
        data_in_odd  = '0;
        rst_n        = 1'b1;
        test_reset();
        test_constant();
        test_ramp();
        test_detail_clamp();
        test_mid_reset();
        test_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
